dm_port_arbiter: RTL and testbench

Arbitrates the single data-memory port of `memory` between the core (DAG/program-sequencer path) and a DMA requester. It issues one DM command per cycle on `ps_dm_cslt`/`ps_dm_wrb`/`dg_dm_add`. It re-times write data onto `bc_dt` one cycle after the command, because `memory` commits writes at execute+1, and it steers `dm_bc_dt` read data back to the owning requester. The core has fixed priority. A starvation counter guarantees DMA forward progress.

---
 rtl/dm_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - data-memory port arbiter between core and DMA with starvation guard
module dm_port_arbiter #(
  parameter int DMA_SIZE   = 17,
  parameter int DMD_SIZE   = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req,
  input  logic                core_wrb,
  input  logic [DMA_SIZE-1:0] core_add,
  input  logic [DMD_SIZE-1:0] core_dt,
  output logic                core_gnt,
  output logic                core_rvalid,
  output logic [DMD_SIZE-1:0] core_rdata,
  input  logic                dma_req,
  input  logic                dma_wrb,
  input  logic [DMA_SIZE-1:0] dma_add,
  input  logic [DMD_SIZE-1:0] dma_dt,
  output logic                dma_gnt,
  output logic                dma_rvalid,
  output logic [DMD_SIZE-1:0] dma_rdata,
  output logic                ps_dm_cslt,
  output logic                ps_dm_wrb,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] bc_dt,
  input  logic [DMD_SIZE-1:0] dm_bc_dt
);

  typedef enum logic {
    CORE_PRI  = 1'b0,
    DMA_FORCE = 1'b1
  } state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_starve_cnt;
  logic [3:0]            w_starve_nxt;
  logic                  w_core_gnt;
  logic                  w_dma_gnt;
  logic                  w_cmd_wr;
  logic [DMD_SIZE-1:0]   w_wr_dt;
  logic                  r_valid;
  logic                  r_owner_dma;
  logic                  r_wr_inflight;
  logic [DMD_SIZE-1:0]   r_bc_dt;
  logic [DMD_SIZE-1:0]   r_core_rdata;
  logic [DMD_SIZE-1:0]   r_dma_rdata;
  logic                  w_core_rvalid;
  logic                  w_dma_rvalid;

  // Grant selection: core first unless DMA has been starved; nothing granted in reset
  always_comb begin
    w_core_gnt = 1'b0;
    w_dma_gnt  = 1'b0;
    if (rst) begin
      if (r_state == DMA_FORCE) begin
        w_dma_gnt  = dma_req;
        w_core_gnt = core_req & ~dma_req;
      end else begin
        w_core_gnt = core_req;
        w_dma_gnt  = dma_req & ~core_req;
      end
    end
  end

  // Starvation counter and FSM next state; force DMA on the edge the count reaches the limit
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = 4'd0;
    if (dma_req && !w_dma_gnt) begin
      w_starve_nxt = (r_starve_cnt >= LP_STARVE_MAX) ? r_starve_cnt : r_starve_cnt + 4'd1;
    end
    case (r_state)
      CORE_PRI:  if (w_starve_nxt == LP_STARVE_MAX) w_state_nxt = DMA_FORCE;
      DMA_FORCE: if (w_dma_gnt || !dma_req) w_state_nxt = CORE_PRI;
      default:   w_state_nxt = CORE_PRI;
    endcase
  end

  // FSM and starvation counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= CORE_PRI;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Command mux from whichever requester owns the port this cycle
  always_comb begin
    ps_dm_cslt = w_core_gnt | w_dma_gnt;
    ps_dm_wrb  = 1'b0;
    dg_dm_add  = '0;
    w_wr_dt    = dma_dt;
    if (w_core_gnt) begin
      ps_dm_wrb = core_wrb;
      dg_dm_add = core_add;
      w_wr_dt   = core_dt;
    end else if (w_dma_gnt) begin
      ps_dm_wrb = dma_wrb;
      dg_dm_add = dma_add;
    end
    w_cmd_wr = ps_dm_cslt & ps_dm_wrb;
  end

  // Write-data retiming and read-return tracking; a write already issued survives a reset edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid       <= 1'b0;
      r_owner_dma   <= 1'b0;
      r_wr_inflight <= 1'b0;
      r_core_rdata  <= '0;
      r_dma_rdata   <= '0;
      if (!r_wr_inflight) r_bc_dt <= '0;
    end else begin
      r_valid       <= ps_dm_cslt & ~ps_dm_wrb;
      r_owner_dma   <= w_dma_gnt;
      r_wr_inflight <= w_cmd_wr;
      if (w_cmd_wr)      r_bc_dt      <= w_wr_dt;
      if (w_core_rvalid) r_core_rdata <= dm_bc_dt;
      if (w_dma_rvalid)  r_dma_rdata  <= dm_bc_dt;
    end
  end

  // Read return steering; a read in flight when reset asserts is squashed
  always_comb begin
    w_core_rvalid = rst & r_valid & ~r_owner_dma;
    w_dma_rvalid  = rst & r_valid & r_owner_dma;
  end

  assign core_gnt    = w_core_gnt;
  assign dma_gnt     = w_dma_gnt;
  assign core_rvalid = w_core_rvalid;
  assign dma_rvalid  = w_dma_rvalid;
  assign core_rdata  = w_core_rvalid ? dm_bc_dt : r_core_rdata;
  assign dma_rdata   = w_dma_rvalid ? dm_bc_dt : r_dma_rdata;
  assign bc_dt       = r_bc_dt;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - scoreboard bench for dm_port_arbiter with a small DM model
module tb_dm_port_arbiter;
  localparam int AW = 17;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_req = 1'b0, core_wrb = 1'b0;
  logic [AW-1:0] core_add = '0;
  logic [DW-1:0] core_dt = '0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          dma_req = 1'b0, dma_wrb = 1'b0;
  logic [AW-1:0] dma_add = '0;
  logic [DW-1:0] dma_dt = '0;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          ps_dm_cslt, ps_dm_wrb;
  logic [AW-1:0] dg_dm_add;
  logic [DW-1:0] bc_dt;
  logic [DW-1:0] dm_bc_dt = '0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.DMA_SIZE(AW), .DMD_SIZE(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_wrb(core_wrb), .core_add(core_add), .core_dt(core_dt),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_wrb(dma_wrb), .dma_add(dma_add), .dma_dt(dma_dt),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb), .dg_dm_add(dg_dm_add),
    .bc_dt(bc_dt), .dm_bc_dt(dm_bc_dt)
  );

  // DM model: write committed at execute+1 from bc_dt, read data one cycle later with bypass
  logic [DW-1:0] mem [0:63];
  logic          m_loaded = 1'b0;
  logic          m_wpend = 1'b0;
  logic [5:0]    m_waddr = '0;
  always @(posedge clk) begin
    if (!m_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i < 4) ? DW'(16'h1000 + i) : '0;
      mem[10]  <= 16'h1234;
      m_loaded <= 1'b1;
    end else begin
      if (m_wpend) mem[m_waddr] <= bc_dt;
      if (ps_dm_cslt && !ps_dm_wrb)
        dm_bc_dt <= (m_wpend && m_waddr == dg_dm_add[5:0]) ? bc_dt : mem[dg_dm_add[5:0]];
      m_wpend <= ps_dm_cslt & ps_dm_wrb;
      m_waddr <= dg_dm_add[5:0];
    end
  end

  typedef struct packed {
    logic          owner_dma;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    core_req = 0; core_wrb = 0; core_add = '0; core_dt = '0;
    dma_req  = 0; dma_wrb  = 0; dma_add  = '0; dma_dt  = '0;
  endtask

  task automatic core_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req = 1; core_wrb = w; core_add = a; core_dt = d;
  endtask

  task automatic dma_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = 1; dma_wrb = w; dma_add = a; dma_dt = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected response whenever a read return is presented
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      chk("gnt_overlap", {31'd0, core_gnt & dma_gnt}, 32'd0);
      if (core_rvalid || dma_rvalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rvalid: core_rvalid=%0b dma_rvalid=%0b, expected none", core_rvalid, dma_rvalid);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_owner", {30'd0, core_rvalid, dma_rvalid}, e.owner_dma ? 32'd1 : 32'd2);
          chk("rsp_data", e.owner_dma ? dma_rdata : core_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 0;
    repeat (3) next_cycle();
    rst = 1;
    #1;
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_cslt", ps_dm_cslt, 0);
    chk("rst_add", dg_dm_add, 0);
    chk("rst_bc_dt", bc_dt, 0);
    chk("rst_rvalid", {core_rvalid, dma_rvalid}, 0);
    chk("rst_rdata", {core_rdata, dma_rdata}, 0);

    // Core read of 0x0000A
    next_cycle();
    core_cmd(0, 17'h0000A, '0);
    #1;
    chk("rd_core_gnt", core_gnt, 1);
    chk("rd_dma_gnt", dma_gnt, 0);
    chk("rd_cslt", ps_dm_cslt, 1);
    chk("rd_wrb", ps_dm_wrb, 0);
    chk("rd_add", dg_dm_add, 17'h0000A);
    exp_q.push_back('{owner_dma: 1'b0, data: 16'h1234});
    next_cycle();
    idle();
    #1;
    chk("rd_core_rvalid", core_rvalid, 1);
    chk("rd_dma_rvalid", dma_rvalid, 0);
    chk("rd_dma_rdata_hold", dma_rdata, 0);
    chk("idle_cslt", ps_dm_cslt, 0);
    chk("idle_add", dg_dm_add, 0);

    // Core write then read-after-write to 0x0000F
    next_cycle();
    core_cmd(1, 17'h0000F, 16'hFFEE);
    #1;
    chk("wr_core_gnt", core_gnt, 1);
    chk("wr_wrb", ps_dm_wrb, 1);
    next_cycle();
    core_cmd(0, 17'h0000F, '0);
    #1;
    chk("raw_bc_dt", bc_dt, 16'hFFEE);
    chk("raw_core_gnt", core_gnt, 1);
    exp_q.push_back('{owner_dma: 1'b0, data: 16'hFFEE});
    next_cycle();
    idle();

    // Continuous contention: DMA forced at cycles 4 and 9
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      core_cmd(1, 17'h00030, 16'hC0C0);
      dma_cmd(1, 17'h00031, 16'hD0D0);
      #1;
      chk($sformatf("cont_core_gnt_%0d", i), core_gnt, (i == 4 || i == 9) ? 0 : 1);
      chk($sformatf("cont_dma_gnt_%0d", i), dma_gnt, (i == 4 || i == 9) ? 1 : 0);
      chk($sformatf("cont_add_%0d", i), dg_dm_add, (i == 4 || i == 9) ? 17'h00031 : 17'h00030);
      if (i == 5) chk("cont_bc_dt_dma", bc_dt, 16'hD0D0);
      if (i == 6) chk("cont_bc_dt_core", bc_dt, 16'hC0C0);
    end
    next_cycle();
    idle();

    // DMA-only back-to-back reads of 0..3
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      dma_cmd(0, AW'(i), '0);
      #1;
      chk($sformatf("dmard_gnt_%0d", i), dma_gnt, 1);
      chk($sformatf("dmard_add_%0d", i), dg_dm_add, i);
      exp_q.push_back('{owner_dma: 1'b1, data: DW'(16'h1000 + i)});
    end
    next_cycle();
    idle();

    // DMA write 0x00005 <- 0xBEEF, reset in the following cycle
    next_cycle();
    dma_cmd(1, 17'h00005, 16'hBEEF);
    #1;
    chk("rstwr_dma_gnt", dma_gnt, 1);
    next_cycle();
    idle();
    core_cmd(0, 17'h0000A, '0);
    rst = 0;
    #1;
    chk("rstwr_bc_dt", bc_dt, 16'hBEEF);
    chk("rstwr_core_gnt", core_gnt, 0);
    chk("rstwr_dma_gnt_low", dma_gnt, 0);
    chk("rstwr_cslt", ps_dm_cslt, 0);
    chk("rstwr_rvalid", {core_rvalid, dma_rvalid}, 0);
    next_cycle();
    rst = 1;
    idle();
    #1;
    chk("rstwr_mem5", mem[5], 16'hBEEF);
    chk("rstwr_rvalid_after", {core_rvalid, dma_rvalid}, 0);
    core_cmd(0, 17'h00005, '0);
    #1;
    chk("rstwr_rd5_gnt", core_gnt, 1);
    exp_q.push_back('{owner_dma: 1'b0, data: 16'hBEEF});

    // Reach DMA_FORCE, then reset: core must win first after release
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      core_cmd(1, 17'h00030, 16'hC1C1);
      dma_cmd(1, 17'h00031, 16'hD1D1);
    end
    next_cycle();
    rst = 0;
    #1;
    chk("frst_dma_gnt", dma_gnt, 0);
    chk("frst_core_gnt", core_gnt, 0);
    next_cycle();
    rst = 1;
    #1;
    chk("frst_core_first", core_gnt, 1);
    chk("frst_dma_wait", dma_gnt, 0);
    next_cycle();
    idle();

    // Reset with a core read in flight: its rvalid is squashed
    next_cycle();
    core_cmd(0, 17'h0000A, '0);
    #1;
    chk("rdrst_core_gnt", core_gnt, 1);
    next_cycle();
    idle();
    rst = 0;
    #1;
    chk("rdrst_core_rvalid", core_rvalid, 0);
    next_cycle();
    next_cycle();
    rst = 1;
    #1;
    chk("rdrst_bc_dt", bc_dt, 0);
    chk("rdrst_core_rdata", core_rdata, 0);
    chk("rdrst_cslt", ps_dm_cslt, 0);

    repeat (3) next_cycle();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
